// File: rtl/mux_scan_pkg.sv
// Shared types and channel-selection helpers for the 4:1 mux scan sequencer.
package mux_scan_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } scan_state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] ch;
    } ch_pick_t;

    // Lowest set mask bit strictly above ch; found=0 means the scan is complete.
    function automatic ch_pick_t next_ch(input logic [NUM_CH-1:0] mask,
                                         input logic [SEL_W-1:0]  ch);
        ch_pick_t r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i > int'(ch) && mask[i]) begin
                r.found = 1'b1;
                r.ch    = SEL_W'(i);
            end
        end
        return r;
    endfunction

    function automatic ch_pick_t first_ch(input logic [NUM_CH-1:0] mask);
        ch_pick_t r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                r.found = 1'b1;
                r.ch    = SEL_W'(i);
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/settle_timer.sv
// Per-channel settle down-counter; tick_zero marks the sampling edge.
module settle_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] value,
    output logic          tick_zero
);
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tick_zero = (cnt_q == '0);
endmodule

// File: rtl/mux_scan_sequencer.sv
// Walks the 4:1 mux select over enabled channels, samples Y per channel and
// hands the resulting snapshot downstream over valid/ready.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_CH-1:0]   enable_mask,
    input  logic                Y_in,
    output logic [SEL_W-1:0]    S,
    output logic [NUM_CH-1:0]   snapshot,
    output logic                valid,
    input  logic                ready,
    output logic                busy
);
    localparam int            CW     = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

    scan_state_t       state_q;
    logic [SEL_W-1:0]  ch_q;
    logic [SEL_W-1:0]  S_q;
    logic [NUM_CH-1:0] mask_q;
    logic [NUM_CH-1:0] snap_q;
    logic              valid_q;
    logic              busy_q;

    logic     tick_zero;
    logic     tmr_load;
    ch_pick_t first_pick;
    ch_pick_t nxt_pick;

    assign first_pick = first_ch(enable_mask);
    assign nxt_pick   = next_ch(mask_q, ch_q);

    // Timer reloads on scan entry and on every hop to another enabled channel.
    assign tmr_load = (state_q == IDLE   && start && first_pick.found) ||
                      (state_q == SETTLE && tick_zero && nxt_pick.found);

    settle_timer #(.CW(CW)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load),
        .value     (RELOAD),
        .tick_zero (tick_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            S_q     <= '0;
            mask_q  <= '0;
            snap_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mask_q <= enable_mask;
                        snap_q <= '0;
                        busy_q <= 1'b1;
                        if (first_pick.found) begin
                            state_q <= SETTLE;
                            ch_q    <= first_pick.ch;
                            S_q     <= first_pick.ch;
                        end else begin
                            state_q <= DONE;
                            valid_q <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (tick_zero) begin
                        snap_q[ch_q] <= Y_in;
                        if (nxt_pick.found) begin
                            ch_q <= nxt_pick.ch;
                            S_q  <= nxt_pick.ch;
                        end else begin
                            state_q <= DONE;
                            S_q     <= '0;
                            valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    S_q     <= '0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign S        = S_q;
    assign snapshot = snap_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench: two sequencers (SETTLE_CYCLES=2 and 1) each driving a 4:1 mux model.
module tb_mux_scan_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic [3:0] en_mask;
    logic       ready;
    logic [3:0] data;
    logic [1:0] S_a, S_b;
    logic [3:0] snap_a, snap_b;
    logic       valid_a, valid_b, busy_a, busy_b;
    logic       Y_a, Y_b;
    int         cur;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    assign Y_a = data[S_a];
    assign Y_b = data[S_b];

    mux_scan_sequencer #(.SETTLE_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .enable_mask(en_mask), .Y_in(Y_a),
        .S(S_a), .snapshot(snap_a), .valid(valid_a), .ready(ready), .busy(busy_a));

    mux_scan_sequencer #(.SETTLE_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .enable_mask(en_mask), .Y_in(Y_b),
        .S(S_b), .snapshot(snap_b), .valid(valid_b), .ready(ready), .busy(busy_b));

    logic [1:0] obs_S;
    logic [3:0] obs_snap;
    logic       obs_valid, obs_busy;
    assign obs_S     = (cur != 0) ? S_b     : S_a;
    assign obs_snap  = (cur != 0) ? snap_b  : snap_a;
    assign obs_valid = (cur != 0) ? valid_b : valid_a;
    assign obs_busy  = (cur != 0) ? busy_b  : busy_a;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (cur != 0) start_b = v;
        else start_a = v;
    endtask

    // dmode: 0 = data constant, 1 = toggle D every cycle, 2 = fully random data
    task automatic run_scan(input logic [3:0] mask, input logic [3:0] d0,
                            input int dmode, input int hold);
        int         sc;
        int         q[$];
        logic [3:0] exp_snap;
        sc = (cur != 0) ? 1 : 2;
        exp_snap = 4'h0;
        for (int n = 0; n < 4; n++)
            if (mask[n]) for (int k = 0; k < sc; k++) q.push_back(n);

        @(negedge clk);
        chk("idle_valid", 8'(obs_valid), 8'd0);
        chk("idle_busy",  8'(obs_busy),  8'd0);
        chk("idle_S",     8'(obs_S),     8'd0);
        data    = d0;
        en_mask = mask;
        ready   = 1'($urandom);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);

        // Each channel is sampled with the data present during its last held cycle.
        for (int i = 0; i < q.size(); i++) begin
            chk("scan_S",     8'(obs_S),     8'(q[i]));
            chk("scan_busy",  8'(obs_busy),  8'd1);
            chk("scan_valid", 8'(obs_valid), 8'd0);
            if (dmode == 1) data[3] = ~data[3];
            else if (dmode == 2) data = 4'($urandom);
            if (i == q.size() - 1 || q[i+1] != q[i]) exp_snap[q[i]] = data[q[i]];
            en_mask = 4'($urandom);
            ready   = 1'($urandom);
            set_start(1'($urandom));
            @(negedge clk);
        end
        set_start(1'b0);
        ready = 1'b0;

        for (int h = 0; h <= hold; h++) begin
            chk("done_valid", 8'(obs_valid), 8'd1);
            chk("done_snap",  8'(obs_snap),  8'(exp_snap));
            chk("done_S",     8'(obs_S),     8'd0);
            chk("done_busy",  8'(obs_busy),  8'd1);
            if (h == hold) begin
                set_start(1'b0);
                ready = 1'b1;
            end else begin
                set_start(1'($urandom));
                data = 4'($urandom);
            end
            @(negedge clk);
        end
        set_start(1'b0);
        ready = 1'b0;
        chk("post_valid", 8'(obs_valid), 8'd0);
        chk("post_busy",  8'(obs_busy),  8'd0);
        chk("post_S",     8'(obs_S),     8'd0);
    endtask

    initial begin
        cur = 0; rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        en_mask = 4'h0; ready = 1'b0; data = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_S",     8'(obs_S),     8'd0);
        chk("rst_snap",  8'(obs_snap),  8'd0);
        chk("rst_valid", 8'(obs_valid), 8'd0);
        chk("rst_busy",  8'(obs_busy),  8'd0);
        rst = 1'b0;

        // Full scan, A..D = 1,0,1,1
        run_scan(4'hF, 4'b1101, 0, 0);
        // Sparse mask, A..D = 1,1,0,1
        run_scan(4'b1010, 4'b1011, 0, 0);
        // Empty mask
        run_scan(4'h0, 4'hF, 2, 0);
        // Backpressure with random data and ignored starts
        run_scan(4'hF, 4'($urandom), 2, 5);

        // Reset while channel 2 is settling
        @(negedge clk);
        en_mask = 4'hF; data = 4'hF; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("pre_rst_S", 8'(obs_S), 8'(i / 2));
            @(negedge clk);
        end
        chk("rst_mid_S", 8'(obs_S), 8'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_S0",    8'(obs_S),     8'd0);
        chk("rst_mid_snap",  8'(obs_snap),  8'd0);
        chk("rst_mid_valid", 8'(obs_valid), 8'd0);
        chk("rst_mid_busy",  8'(obs_busy),  8'd0);
        run_scan(4'hF, 4'b0110, 0, 0);

        // Random scans on the SETTLE_CYCLES=2 instance
        for (int t = 0; t < 6; t++)
            run_scan(4'($urandom), 4'($urandom), 2, int'($urandom_range(0, 3)));

        // SETTLE_CYCLES=1 instance, D toggled each cycle
        cur = 1;
        run_scan(4'hF, 4'b0101, 1, 0);
        run_scan(4'hF, 4'b1010, 1, 2);
        for (int t = 0; t < 6; t++)
            run_scan(4'($urandom), 4'($urandom), 2, int'($urandom_range(0, 3)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
